// File: rtl/nfc_phy_arb.sv
// nfc_phy_arb
// Round-robin arbiter that grants one of N_REQ command requesters ownership
// of a single NFC PHY, forwards the winner's latched command, tracks the PHY
// through its busy/idle status, and reports normal completion or timeout.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   i_req_valid        per-requester command valid
//   o_req_ready        per-requester accept (combinational, IDLE only)
//   i_req_cmd/id       flattened 16-bit command / command ID, slice k = [16k+15:16k]
//   i_req_addr         flattened 48-bit address
//   i_req_param        flattened 32-bit parameter word
//   o_cmd_valid        PHY command valid (ISSUE only)
//   i_cmd_ready        PHY command ready
//   o_cmd, o_cmd_id, o_addr, o_cmd_param   latched payload to the PHY
//   i_status           PHY status: 00 IDLE, 01 BUSY, 10 WAIT, 11 READY
//   o_grant            one-hot current owner, zero when no owner
//   o_done, o_timeout  one-cycle completion / timeout pulses (FIN)
//   o_done_id          ID of the finished operation, valid with the pulses
//   o_dbg_state        current FSM state (IDLE=0 ISSUE=1 START=2 RUN=3 FIN=4)
//
// Handshake: a requester transfer happens on a rising clk edge when
// i_req_valid[k] and o_req_ready[k] are both high; a PHY transfer happens when
// o_cmd_valid and i_cmd_ready are both high. Valid never depends on ready.
module nfc_phy_arb #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      i_req_valid,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic [16*N_REQ-1:0]   i_req_cmd,
    input  logic [16*N_REQ-1:0]   i_req_id,
    input  logic [48*N_REQ-1:0]   i_req_addr,
    input  logic [32*N_REQ-1:0]   i_req_param,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [15:0]           o_cmd,
    output logic [15:0]           o_cmd_id,
    output logic [47:0]           o_addr,
    output logic [31:0]           o_cmd_param,
    input  logic [1:0]            i_status,
    output logic [N_REQ-1:0]      o_grant,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [15:0]           o_done_id,
    output logic [2:0]            o_dbg_state
);

    localparam int                PTR_W  = $clog2(N_REQ);
    localparam logic [15:0]       TO_LIM = 16'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0]  LAST   = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE    = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [15:0]         r_timer;
    logic                r_to_flag;
    logic [N_REQ-1:0]    r_grant;
    logic [15:0]         r_cmd;
    logic [15:0]         r_cmd_id;
    logic [47:0]         r_addr;
    logic [31:0]         r_param;
    logic [PTR_W-1:0]    w_winner;
    logic                w_any;
    logic                w_to_hit;

    // (base + off) mod N_REQ without a divider; off is always < N_REQ.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // Walk offsets from the far end down to 0 so the lowest offset from
    // r_rr_ptr with a valid request is the last (winning) assignment.
    always_comb begin
        w_winner = r_rr_ptr;
        w_any    = |i_req_valid;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[rr_idx(r_rr_ptr, i)]) w_winner = rr_idx(r_rr_ptr, i);
        end
    end

    // Timeout beats a status transition seen in the same cycle.
    assign w_to_hit = (r_timer == TO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_cmd_valid = 1'b0;
        o_done      = 1'b0;
        o_timeout   = 1'b0;
        o_done_id   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    // Gated with rst_n so ready is low throughout reset.
                    o_req_ready[w_winner] = rst_n;
                    w_state_nxt           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_cmd_valid = 1'b1;
                if (i_cmd_ready) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_to_hit)               w_state_nxt = S_FIN;
                else if (i_status != 2'b00) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_to_hit || i_status == 2'b00) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                o_done      = ~r_to_flag;
                o_timeout   = r_to_flag;
                o_done_id   = r_cmd_id;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_timer   <= '0;
            r_to_flag <= 1'b0;
            r_grant   <= '0;
            r_cmd     <= '0;
            r_cmd_id  <= '0;
            r_addr    <= '0;
            r_param   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_winner;
                        r_grant   <= ONE << w_winner;
                        r_cmd     <= i_req_cmd[16*w_winner +: 16];
                        r_cmd_id  <= i_req_id[16*w_winner +: 16];
                        r_addr    <= i_req_addr[48*w_winner +: 48];
                        r_param   <= i_req_param[32*w_winner +: 32];
                        r_to_flag <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (i_cmd_ready) r_timer <= '0;
                end
                S_START, S_RUN: begin
                    if (r_timer != 16'hFFFF) r_timer <= r_timer + 16'd1;
                    if (w_to_hit) r_to_flag <= 1'b1;
                end
                S_FIN: begin
                    r_rr_ptr <= (r_owner == LAST) ? '0 : r_owner + 1'b1;
                    r_grant  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_cmd       = r_cmd;
    assign o_cmd_id    = r_cmd_id;
    assign o_addr      = r_addr;
    assign o_cmd_param = r_param;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nfc_phy_arb.sv
module tb_nfc_phy_arb;
  localparam int N = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    i_req_valid = '0;
  logic [N-1:0]    o_req_ready;
  logic [16*N-1:0] i_req_cmd, i_req_id;
  logic [48*N-1:0] i_req_addr;
  logic [32*N-1:0] i_req_param;
  logic            o_cmd_valid;
  logic            i_cmd_ready = 1'b0;
  logic [15:0]     o_cmd, o_cmd_id, o_done_id;
  logic [47:0]     o_addr;
  logic [31:0]     o_cmd_param;
  logic [1:0]      i_status = 2'b00;
  logic [N-1:0]    o_grant;
  logic            o_done, o_timeout;
  logic [2:0]      o_dbg_state;

  logic [15:0] cmd_a [N];
  logic [15:0] id_a [N];
  logic [47:0] addr_a [N];
  logic [31:0] par_a [N];

  // scoreboard entry: {timeout, done, id}
  logic [17:0] exp_q[$];
  logic [17:0] sb_e;
  int n_assert = 0;
  int n_fail = 0;

  nfc_phy_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_cmd(i_req_cmd), .i_req_id(i_req_id),
    .i_req_addr(i_req_addr), .i_req_param(i_req_param),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd(o_cmd), .o_cmd_id(o_cmd_id), .o_addr(o_addr), .o_cmd_param(o_cmd_param),
    .i_status(i_status), .o_grant(o_grant),
    .o_done(o_done), .o_timeout(o_timeout), .o_done_id(o_done_id),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      i_req_cmd[16*k +: 16]   = cmd_a[k];
      i_req_id[16*k +: 16]    = id_a[k];
      i_req_addr[48*k +: 48]  = addr_a[k];
      i_req_param[32*k +: 32] = par_a[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < N; k++) begin
      cmd_a[k]  = 16'($urandom);
      id_a[k]   = 16'($urandom);
      addr_a[k] = {16'($urandom), 32'($urandom)};
      par_a[k]  = 32'($urandom);
    end
  endtask

  // Arbitrate and hand the command to the PHY; returns at the negedge after
  // the PHY accept edge with the DUT in START.
  task automatic issue_op(input logic [N-1:0] vmask, input int exp_k, input int rdy_dly,
                          input logic exp_to);
    int n;
    logic [N-1:0] m;
    logic [15:0] e_cmd, e_id;
    logic [47:0] e_addr;
    logic [31:0] e_par;
    m = 4'b0001 << exp_k;
    i_req_valid = vmask;
    #1;
    n = 0;
    while (o_req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("req_ready", o_req_ready, m);
    e_cmd = cmd_a[exp_k]; e_id = id_a[exp_k]; e_addr = addr_a[exp_k]; e_par = par_a[exp_k];
    exp_q.push_back({exp_to, ~exp_to, e_id});
    @(posedge clk);
    @(negedge clk);
    rand_payload();
    i_status = 2'b11;
    #1;
    check("grant", o_grant, m);
    check("req_ready_low", o_req_ready, 0);
    check("cmd_valid", o_cmd_valid, 1);
    check("state_issue", o_dbg_state, 1);
    check("cmd", o_cmd, e_cmd);
    check("cmd_id", o_cmd_id, e_id);
    check("addr", o_addr, e_addr);
    check("param", o_cmd_param, e_par);
    for (int d = 0; d < rdy_dly; d++) begin
      @(negedge clk); #1;
      check("cmd_valid_hold", o_cmd_valid, 1);
      check("cmd_id_hold", o_cmd_id, e_id);
    end
    i_cmd_ready = 1'b1;
    @(posedge clk); #1;
    i_cmd_ready = 1'b0;
    i_status = 2'b00;
    @(negedge clk); #1;
    check("cmd_valid_drop", o_cmd_valid, 0);
    check("state_start", o_dbg_state, 2);
  endtask

  // mode 0: busy for 'busy' cycles then idle; 1: status stuck at WAIT;
  // 2: busy, dropping to idle in the cycle the timer hits its limit.
  task automatic run_phy(input int mode, input int busy);
    int cnt;
    cnt = 0;
    if (mode == 0) begin
      i_status = 2'b01;
      repeat (busy) @(negedge clk);
      #1;
      check("state_run", o_dbg_state, 3);
      i_status = 2'b00;
    end else if (mode == 1) begin
      i_status = 2'b10;
    end else begin
      i_status = 2'b01;
    end
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (mode == 2 && cnt == TO - 1) i_status = 2'b00;
      #1;
      if (o_done || o_timeout) break;
      if (mode != 0) check("early_fin", {o_done, o_timeout}, 0);
    end
    check("fin_seen", (cnt < 40), 1);
    if (mode != 0) check("to_latency", cnt, TO);
    i_status = 2'b00;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (o_done || o_timeout)) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        check("done_kind", {o_timeout, o_done}, sb_e[17:16]);
        check("done_id", o_done_id, sb_e[15:0]);
      end
    end
  end

  initial begin
    rand_payload();
    i_req_valid = 4'b1111;
    #12;
    check("rst_ready", o_req_ready, 0);
    check("rst_grant", o_grant, 0);
    check("rst_cmd_valid", o_cmd_valid, 0);
    check("rst_done", {o_done, o_timeout}, 0);
    check("rst_done_id", o_done_id, 0);
    check("rst_payload", {o_cmd, o_cmd_id, o_cmd_param}, 0);
    check("rst_state", o_dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all requesters held valid: round robin 0,1,2,3,0
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
        issue_op(4'b1111, order[i], $urandom_range(0, 2), 1'b0);
        run_phy(0, $urandom_range(1, 3));
      end
    end

    // single requester 2 with a fixed ID, PHY ready on the third cycle
    id_a[2] = 16'h00A5;
    issue_op(4'b0100, 2, 2, 1'b0);
    run_phy(0, 1);

    // stuck in WAIT: timeout, then the next requester wins
    issue_op(4'b1111, 3, 0, 1'b1);
    run_phy(1, 0);
    issue_op(4'b1111, 0, 1, 1'b0);
    run_phy(0, 2);

    // status returns to IDLE the same cycle the timer expires
    issue_op(4'b1111, 1, 0, 1'b1);
    run_phy(2, 0);

    // reset in the middle of RUN
    issue_op(4'b1111, 2, 0, 1'b0);
    i_status = 2'b01;
    @(negedge clk); #1;
    check("pre_rst_state", o_dbg_state, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", o_dbg_state, 0);
    check("mid_rst_grant", o_grant, 0);
    check("mid_rst_ready", o_req_ready, 0);
    check("mid_rst_cmd_valid", o_cmd_valid, 0);
    check("mid_rst_pulses", {o_done, o_timeout}, 0);
    check("mid_rst_payload", {o_cmd_id, o_addr}, 0);
    exp_q.delete();
    i_req_valid = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    i_status = 2'b00;
    issue_op(4'b0010, 1, 0, 1'b0);
    run_phy(0, 1);

    i_req_valid = '0;
    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
